serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_if.sv | 44 ++++
 rtl/serial_addsub.sv | 113 +++++++++++
 tb/tb_serial_addsub.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// -----------------------------------------------------------------------------
// serial_addsub_if -- operand/handshake bundle for the bit-serial add/subtract
// unit.
//
// The master drives the parallel operands and the control strobes. The slave,
// which is the arithmetic unit, returns the accumulator and its status flags.
//
//   load      master->slave  parallel load of the A and B registers
//   a_in      master->slave  WIDTH-bit value for accumulator A
//   b_in      master->slave  WIDTH-bit value for operand register B
//   start     master->slave  begin one serial operation
//   sub       master->slave  operation select, sampled with start (1 = A-B)
//   hold      master->slave  freeze the serial datapath for one cycle
//   acc       slave->master  current contents of A
//   carry_out slave->master  carry flip-flop (for subtract, 1 = no borrow)
//   overflow  slave->master  two's-complement overflow of the last operation
//   busy      slave->master  high while shifting
//   done      slave->master  one-cycle completion pulse
// -----------------------------------------------------------------------------
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             start;
    logic             sub;
    logic             hold;
    logic [WIDTH-1:0] acc;
    logic             carry_out;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output load, a_in, b_in, start, sub, hold,
        input  acc, carry_out, overflow, busy, done
    );

    modport slave (
        input  load, a_in, b_in, start, sub, hold,
        output acc, carry_out, overflow, busy, done
    );
endinterface

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub -- bit-serial two's-complement adder/subtractor with
// accumulator.
//
// A (the accumulator) and B are WIDTH-bit registers. A single operation takes
// WIDTH shift edges. On each edge the LSBs of A and B go through a full adder.
// The sum bit enters the top of A, and B rotates so that its value is intact
// afterwards. Subtraction inverts the B bits and seeds the carry with 1. A
// start issued without a new load therefore keeps adding or subtracting B
// into A.
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   bus    serial_addsub_if.slave (operands, controls, result and flags)
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic            clock,
    input  logic            reset,
    serial_addsub_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic             ovf_q;
    logic             mode_q;
    logic [CW-1:0]    cnt_q;

    // One full-adder slice on the current LSBs.
    logic             b_bit;
    logic             sum_d;
    logic             carry_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic             last_shift;

    always_comb begin
        b_bit      = b_q[0] ^ mode_q;
        sum_d      = a_q[0] ^ b_bit ^ carry_q;
        carry_d    = (a_q[0] & b_bit) | (a_q[0] & carry_q) | (b_bit & carry_q);
        a_d        = {sum_d, a_q[WIDTH-1:1]};
        b_d        = {b_q[0], b_q[WIDTH-1:1]};
        last_shift = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Load takes priority, so a start in the same cycle is dropped.
                    if (bus.load) begin
                        a_q     <= bus.a_in;
                        b_q     <= bus.b_in;
                        ovf_q   <= 1'b0;
                        carry_q <= 1'b0;
                    end else if (bus.start) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        mode_q  <= bus.sub;
                        // The +1 of the two's-complement negation enters as carry-in.
                        carry_q <= bus.sub;
                    end
                end
                SHIFT: begin
                    if (!bus.hold) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        carry_q <= carry_d;
                        cnt_q   <= cnt_q + CW'(1);
                        if (last_shift) begin
                            // On the MSB slice, carry_q is the carry into the MSB.
                            ovf_q   <= carry_q ^ carry_d;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.acc       = a_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = (state_q == SHIFT);
    assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8). It runs directed cases and
// then random load/op sequences. The reference model is plain integer
// arithmetic on A and B.
module tb_serial_addsub;
    localparam int W   = 8;
    localparam int MOD = 1 << W;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    serial_addsub_if #(.WIDTH(W)) ifc ();
    serial_addsub #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(ifc));

    int n_cmp = 0;
    int n_bad = 0;

    // reference state
    int m_a, m_b, m_c, m_v;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; return sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int sx(input int v);
        return (v >= MOD / 2) ? v - MOD : v;
    endfunction

    function automatic void model_op(input bit s);
        int r, sr;
        if (s) begin
            r  = m_a - m_b;
            sr = sx(m_a) - sx(m_b);
            m_c = (m_a >= m_b) ? 1 : 0;
        end else begin
            r  = m_a + m_b;
            sr = sx(m_a) + sx(m_b);
            m_c = (r >= MOD) ? 1 : 0;
        end
        m_v = (sr < -(MOD / 2) || sr > MOD / 2 - 1) ? 1 : 0;
        m_a = ((r % MOD) + MOD) % MOD;
    endfunction

    task automatic check_flags(input string tag);
        chk({tag, ".acc"},  int'(ifc.acc),       m_a);
        chk({tag, ".cy"},   int'(ifc.carry_out), m_c);
        chk({tag, ".ovf"},  int'(ifc.overflow),  m_v);
    endtask

    task automatic do_load(input int a, input int b);
        ifc.load = 1'b1; ifc.a_in = W'(a); ifc.b_in = W'(b);
        tick();
        ifc.load = 1'b0;
        m_a = a; m_b = b; m_c = 0; m_v = 0;
        chk("load.busy", int'(ifc.busy), 0);
        check_flags("load");
    endtask

    // One operation: optional hold burst (hs = first held edge index, nh edges)
    // and optional noise on start/load/sub/a_in while busy.
    task automatic do_op(input string tag, input bit s, input int hs, input int nh, input bit noise);
        int n;
        bit busy_ok;
        ifc.start = 1'b1; ifc.sub = s;
        tick();
        ifc.start = 1'b0;
        n = 0;
        busy_ok = 1'b1;
        while (!ifc.done && n < 200) begin
            if (!ifc.busy) busy_ok = 1'b0;
            ifc.hold = (n >= hs && n < hs + nh);
            if (noise) begin
                ifc.start = 1'($urandom); ifc.load = 1'($urandom);
                ifc.sub = 1'($urandom); ifc.a_in = W'($urandom);
            end
            tick();
            n++;
        end
        ifc.hold = 1'b0; ifc.start = 1'b0; ifc.load = 1'b0;
        model_op(s);
        chk({tag, ".lat"}, n, W + nh);
        chk({tag, ".busy"}, int'(busy_ok), 1);
        check_flags(tag);
        if (noise) begin
            // start/load held across the DONE edge must not be honoured
            ifc.start = 1'b1; ifc.load = 1'b1;
        end
        tick();
        ifc.start = 1'b0; ifc.load = 1'b0;
        chk({tag, ".done1"}, int'(ifc.done), 0);
        chk({tag, ".idle"},  int'(ifc.busy), 0);
        chk({tag, ".keep"},  int'(ifc.acc),  m_a);
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        ifc.load = 1'b0; ifc.start = 1'b0; ifc.sub = 1'b0; ifc.hold = 1'b0;
        ifc.a_in = '0; ifc.b_in = '0;
        tick(); tick();
        reset = 1'b0;
        m_a = 0; m_b = 0; m_c = 0; m_v = 0;
        check_flags("rst");
        chk("rst.busy", int'(ifc.busy), 0);
        chk("rst.done", int'(ifc.done), 0);

        // directed vectors
        do_load(8'h35, 8'h4A); do_op("add", 1'b0, 0, 0, 1'b0);
        chk("add.val", int'(ifc.acc), 8'h7F);
        do_load(8'h10, 8'h20); do_op("sub", 1'b1, 0, 0, 1'b0);
        chk("sub.val", int'(ifc.acc), 8'hF0);
        do_load(8'h80, 8'h01); do_op("subv", 1'b1, 0, 0, 1'b0);
        chk("subv.ovf", int'(ifc.overflow), 1);
        do_load(8'h7F, 8'h01); do_op("addv", 1'b0, 0, 0, 1'b0);
        chk("addv.val", int'(ifc.acc), 8'h80);
        do_op("accum", 1'b0, 0, 0, 1'b0);
        chk("accum.val", int'(ifc.acc), 8'h81);
        do_load(8'h35, 8'h4A); do_op("hold", 1'b0, 3, 3, 1'b0);
        chk("hold.val", int'(ifc.acc), 8'h7F);
        do_load(8'h12, 8'h34); do_op("noise", 1'b1, 0, 0, 1'b1);

        // load and start together: load only
        ifc.load = 1'b1; ifc.start = 1'b1; ifc.a_in = 8'hAA; ifc.b_in = 8'h55;
        tick();
        ifc.load = 1'b0; ifc.start = 1'b0;
        m_a = 8'hAA; m_b = 8'h55; m_c = 0; m_v = 0;
        chk("ldst.busy", int'(ifc.busy), 0);
        check_flags("ldst");
        tick();
        chk("ldst.busy2", int'(ifc.busy), 0);

        // reset after 4 shift edges: abort with no done pulse
        do_load(8'h7F, 8'h01);
        do_op("pre", 1'b0, 0, 0, 1'b0);         // leaves overflow=1
        ifc.start = 1'b1; ifc.sub = 1'b0;
        tick();
        ifc.start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_a = 0; m_b = 0; m_c = 0; m_v = 0;
        check_flags("abort");
        chk("abort.busy", int'(ifc.busy), 0);
        seen = 0;
        repeat (W + 4) begin
            if (ifc.done) seen++;
            tick();
        end
        chk("abort.nodone", seen, 0);

        // random sequences
        for (int i = 0; i < 40; i++) begin
            int nh;
            if ($urandom_range(0, 3) != 0) do_load(int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)));
            nh = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_op("rnd", 1'($urandom), int'($urandom_range(0, W - 1)), nh, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
